pc_sequencer: RTL and testbench

Program-counter sequencer at the front of the pipeline and the consumer of the branch unit's redirect outputs. Holds the fetch PC and issues one instruction-memory request at a time over a valid/ready handshake. On each accepted fetch it advances by 4 or to a redirect target. Redirects that arrive while a request is stalled or outstanding are buffered and never lost.

---
 rtl/pc_sequencer_pkg.sv | 17 +
 rtl/pc_sequencer_redirect_buffer.sv | 44 ++++
 rtl/pc_sequencer.sv | 114 +++++++++++
 tb/tb_pc_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the fetch-PC sequencer and its redirect buffer.
package PcSequencerPackage;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    STALLED = 2'd2,
    HALTED  = 2'd3
  } PcStates;

  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic logic [31:0] wordAlign(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_redirect_buffer.sv
// Single-entry redirect buffer: one target, a valid flag and a one-bit remaining-delay count.
// A held target becomes due once its delay count has run out; it is consumed on the next fetch acceptance.
module pc_redirect_buffer
  import PcSequencerPackage::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        consume,
  input  logic        capture,
  input  logic [31:0] captureTarget,
  input  logic        captureDelay,
  output logic        due,
  output logic [31:0] target
);

  logic        valid;
  logic        delay;
  logic        keepValid;
  logic        keepDelay;

  // An acceptance either retires a due entry or burns one unit of delay off a waiting one.
  always_comb begin
    due       = valid && !delay;
    keepValid = valid && !(consume && !delay);
    keepDelay = delay && !consume;
  end

  // Capture over a surviving entry overwrites only the target, so the newer redirect inherits the remaining delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid  <= 1'b0;
      delay  <= 1'b0;
      target <= 32'h0000_0000;
    end else if (capture) begin
      valid  <= 1'b1;
      target <= captureTarget;
      delay  <= keepValid ? keepDelay : captureDelay;
    end else begin
      valid  <= keepValid;
      delay  <= keepValid ? keepDelay : 1'b0;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-PC sequencer: FSM, PC register and next-PC mux feeding the instruction-memory handshake.
// Optional feature: define PC_DELAY_SLOT_EN to give every redirect one sequential delay-slot fetch.
module pc_sequencer
  import PcSequencerPackage::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        shouldUseNewPC,
  input  logic [31:0] branchTo,
  input  logic        stall,
  input  logic        halt,
  input  logic        fetchReady,
  output logic        fetchValid,
  output logic [31:0] fetchAddress,
  output logic [31:0] pcAddress,
  output logic        halted,
  output logic        alignError
);

  PcStates     state;
  PcStates     nextState;
  logic        accept;
  logic        redirectLive;
  logic [31:0] redirectTarget;
  logic        useDirect;
  logic        capture;
  logic        captureDelay;
  logic        bufDue;
  logic [31:0] bufTarget;
  logic [31:0] nextPc;

  assign fetchValid     = (state == FETCH);
  assign halted         = (state == HALTED);
  assign accept         = fetchValid && fetchReady;
  assign redirectLive   = shouldUseNewPC && ((state == FETCH) || (state == STALLED));
  assign redirectTarget = wordAlign(branchTo);

`ifdef PC_DELAY_SLOT_EN
  // Every redirect goes through the buffer; one arriving off-acceptance owes an extra sequential fetch.
  assign useDirect    = 1'b0;
  assign captureDelay = !accept;
`else
  assign useDirect    = accept && !bufDue && redirectLive;
  assign captureDelay = 1'b0;
`endif

  assign capture = redirectLive && !useDirect;

  pc_redirect_buffer u_redirect_buffer (
    .clk           (clk),
    .rst           (rst),
    .consume       (accept),
    .capture       (capture),
    .captureTarget (redirectTarget),
    .captureDelay  (captureDelay),
    .due           (bufDue),
    .target        (bufTarget)
  );

  // A due pending target outranks a fresh redirect, which then waits in the buffer for the next acceptance.
  always_comb begin
    nextPc = fetchAddress + PC_STEP;
    if (bufDue) begin
      nextPc = bufTarget;
    end else if (useDirect) begin
      nextPc = redirectTarget;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    nextState = FETCH;
      FETCH: begin
        if (accept) begin
          if (halt) begin
            nextState = HALTED;
          end else if (stall) begin
            nextState = STALLED;
          end else begin
            nextState = FETCH;
          end
        end
      end
      STALLED: begin
        if (!stall) begin
          nextState = FETCH;
        end
      end
      HALTED:  nextState = HALTED;
      default: nextState = IDLE;
    endcase
  end

  // fetchAddress only moves on acceptance, so it stays stable while the memory holds off ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      fetchAddress <= wordAlign(RESET_VECTOR);
      pcAddress    <= wordAlign(RESET_VECTOR);
      alignError   <= 1'b0;
    end else begin
      state      <= nextState;
      alignError <= redirectLive && (branchTo[1:0] != 2'b00);
      if (accept) begin
        pcAddress    <= fetchAddress;
        fetchAddress <= nextPc;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed vectors push expected fetch addresses, a negedge monitor checks each acceptance.
// Expectations follow PC_DELAY_SLOT_EN when the design is built with it.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        shouldUseNewPC;
  logic [31:0] branchTo;
  logic        stall;
  logic        halt;
  logic        fetchReady;
  logic        fetchValid;
  logic [31:0] fetchAddress;
  logic [31:0] pcAddress;
  logic        halted;
  logic        alignError;

  int          checks;
  int          errors;
  logic [31:0] expQ[$];
  logic [31:0] prevExp;

  pc_sequencer #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .shouldUseNewPC (shouldUseNewPC),
    .branchTo       (branchTo),
    .stall          (stall),
    .halt           (halt),
    .fetchReady     (fetchReady),
    .fetchValid     (fetchValid),
    .fetchAddress   (fetchAddress),
    .pcAddress      (pcAddress),
    .halted         (halted),
    .alignError     (alignError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic redirect, input logic [31:0] target,
                               input logic stallIn, input logic haltIn);
    fetchReady     = ready;
    shouldUseNewPC = redirect;
    branchTo       = target;
    stall          = stallIn;
    halt           = haltIn;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted request must match the head of the queue, and pcAddress must show the previous acceptance.
  always @(negedge clk) begin
    if (rst) begin
      prevExp = 32'h0000_0000;
    end else if (fetchValid && fetchReady) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedFetch actual=%h expected=none", fetchAddress);
      end else begin
        logic [31:0] exp;
        exp = expQ.pop_front();
        checkOutput("fetchAddress", fetchAddress, exp);
        checkOutput("pcAddressLag", pcAddress, prevExp);
        prevExp = exp;
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    prevExp = 32'h0000_0000;
    rst = 1'b1;
    fetchReady = 1'b0;
    shouldUseNewPC = 1'b0;
    branchTo = 32'h0;
    stall = 1'b0;
    halt = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checkOutput("rstFetchValid", {31'b0, fetchValid}, 32'd0);
    checkOutput("rstFetchAddress", fetchAddress, 32'h0);
    checkOutput("rstPcAddress", pcAddress, 32'h0);
    checkOutput("rstHalted", {31'b0, halted}, 32'd0);
    checkOutput("rstAlignError", {31'b0, alignError}, 32'd0);

    // Sequential fetch after reset release, then a redirect while the memory withholds ready
    rst = 1'b0;
    checkOutput("idleFetchValid", {31'b0, fetchValid}, 32'd0);
    expQ.push_back(32'h0);
    expQ.push_back(32'h4);
    expQ.push_back(32'h8);
`ifdef PC_DELAY_SLOT_EN
    expQ.push_back(32'hC);
`endif
    expQ.push_back(32'h100);
    applyStimulus(1, 0, 32'h0, 0, 0);
    checkOutput("firstValid", {31'b0, fetchValid}, 32'd1);
    checkOutput("firstAddress", fetchAddress, 32'h0);
    applyStimulus(1, 0, 32'h0, 0, 0);
    applyStimulus(1, 0, 32'h0, 0, 0);
    applyStimulus(0, 1, 32'h100, 0, 0);
    checkOutput("holdAddress1", fetchAddress, 32'h8);
    applyStimulus(0, 0, 32'h0, 0, 0);
    applyStimulus(0, 0, 32'h0, 0, 0);
    checkOutput("holdAddress3", fetchAddress, 32'h8);
    applyStimulus(1, 0, 32'h0, 0, 0);

    // Stall on acceptance, two redirects while stalled: last one wins
    applyStimulus(1, 0, 32'h0, 1, 0);
    checkOutput("stalledValid", {31'b0, fetchValid}, 32'd0);
    applyStimulus(1, 1, 32'h200, 1, 0);
    applyStimulus(1, 1, 32'h300, 1, 0);
    expQ.push_back(32'h104);
    expQ.push_back(32'h300);
    expQ.push_back(32'h100);
    expQ.push_back(32'hFFFF_FFFC);
`ifndef PC_DELAY_SLOT_EN
    expQ.push_back(32'h0);
`endif
    applyStimulus(1, 0, 32'h0, 0, 0);
    checkOutput("resumeValid", {31'b0, fetchValid}, 32'd1);
    applyStimulus(1, 0, 32'h0, 0, 0);

    // Misaligned redirect, then a redirect to the top word to exercise wraparound
    applyStimulus(1, 1, 32'h103, 0, 0);
    checkOutput("alignPulse", {31'b0, alignError}, 32'd1);
    applyStimulus(1, 1, 32'hFFFF_FFFC, 0, 0);
    checkOutput("alignClear", {31'b0, alignError}, 32'd0);
    applyStimulus(1, 0, 32'h0, 0, 0);
`ifdef PC_DELAY_SLOT_EN
    checkOutput("topWordAddress", fetchAddress, 32'hFFFF_FFFC);
`else
    checkOutput("wrapAddress", fetchAddress, 32'h0);
`endif

    // Halt on acceptance; redirects are ignored while halted
    applyStimulus(1, 0, 32'h0, 0, 1);
    checkOutput("haltValid", {31'b0, fetchValid}, 32'd0);
    checkOutput("haltHalted", {31'b0, halted}, 32'd1);
    applyStimulus(1, 1, 32'h701, 1, 0);
    checkOutput("haltDropAlign", {31'b0, alignError}, 32'd0);
    applyStimulus(1, 0, 32'h0, 0, 0);
    checkOutput("haltSticky", {31'b0, halted}, 32'd1);
`ifdef PC_DELAY_SLOT_EN
    checkOutput("haltPcAddress", pcAddress, 32'hFFFF_FFFC);
`else
    checkOutput("haltPcAddress", pcAddress, 32'h0);
`endif
    checkOutput("drainedBeforeReset", 32'(expQ.size()), 32'd0);

    // Reset clears HALTED; then reset again mid-stall with a redirect pending
    rst = 1'b1;
    applyStimulus(0, 0, 32'h0, 0, 0);
    applyStimulus(0, 0, 32'h0, 0, 0);
    checkOutput("resetHalted", {31'b0, halted}, 32'd0);
    checkOutput("resetAddress", fetchAddress, 32'h0);
    rst = 1'b0;
    expQ.push_back(32'h0);
    applyStimulus(1, 0, 32'h0, 0, 0);
    applyStimulus(1, 0, 32'h0, 1, 0);
    applyStimulus(1, 1, 32'h500, 1, 0);
    rst = 1'b1;
    applyStimulus(1, 0, 32'h0, 0, 0);
    applyStimulus(1, 0, 32'h0, 0, 0);
    checkOutput("midStallResetValid", {31'b0, fetchValid}, 32'd0);
    checkOutput("midStallResetPc", pcAddress, 32'h0);
    rst = 1'b0;
    expQ.push_back(32'h0);
    expQ.push_back(32'h4);
    expQ.push_back(32'h8);
    applyStimulus(1, 0, 32'h0, 0, 0);
    applyStimulus(1, 0, 32'h0, 0, 0);
    applyStimulus(1, 0, 32'h0, 0, 0);
    applyStimulus(1, 0, 32'h0, 0, 0);
    applyStimulus(0, 0, 32'h0, 0, 0);
    applyStimulus(0, 0, 32'h0, 0, 0);
    checkOutput("restartAddress", fetchAddress, 32'hC);
    checkOutput("drainedAtEnd", 32'(expQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
